// File: rtl/alu_operand_sequencer.sv
// Load-side sequencer for the ALU datapath. It steers operand A, operand B and
// the opcode onto a shared load bus, waits for the ALU to settle, then hands the result downstream.
module alu_operand_sequencer #(
  parameter int WIDTH       = 8,
  parameter int EXEC_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] load_d,
  output logic             en_a,
  output logic             en_b,
  output logic             en_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    GET_OP,
    EXEC,
    RESULT
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

  state_t           state, state_n;
  logic             armed;
  logic [3:0]       cnt, cnt_n;
  logic [WIDTH-1:0] load_d_n, out_data_n;
  logic             en_a_n, en_b_n, en_op_n, out_valid_n;
  logic             xfer;

  // armed keeps in_ready low until the first clock edge after reset release
  always_comb begin
    in_ready = 1'b0;
    if (armed) begin
      case (state)
        GET_A, GET_B, GET_OP: in_ready = 1'b1;
        default:              in_ready = 1'b0;
      endcase
    end
  end

  assign xfer = in_valid & in_ready;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    load_d_n    = load_d;
    out_data_n  = out_data;
    out_valid_n = out_valid;
    en_a_n      = 1'b0;
    en_b_n      = 1'b0;
    en_op_n     = 1'b0;
    if (clear) begin
      state_n     = GET_A;
      cnt_n       = 4'd0;
      out_valid_n = 1'b0;
    end else begin
      case (state)
        GET_A: begin
          if (xfer) begin
            load_d_n = in_data;
            en_a_n   = 1'b1;
            state_n  = GET_B;
          end
        end
        GET_B: begin
          if (xfer) begin
            load_d_n = in_data;
            en_b_n   = 1'b1;
            state_n  = GET_OP;
          end
        end
        GET_OP: begin
          if (xfer) begin
            load_d_n = in_data;
            en_op_n  = 1'b1;
            cnt_n    = 4'd0;
            state_n  = EXEC;
          end
        end
        EXEC: begin
          // the opcode register loads on the edge after en_op, so the count covers that edge too
          if (cnt == LAST_CNT) begin
            out_data_n  = alu_result;
            out_valid_n = 1'b1;
            state_n     = RESULT;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        RESULT: begin
          if (out_valid && out_ready) begin
            out_valid_n = 1'b0;
            state_n     = GET_A;
          end
        end
        default: state_n = GET_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= GET_A;
      armed     <= 1'b0;
      cnt       <= 4'd0;
      load_d    <= '0;
      en_a      <= 1'b0;
      en_b      <= 1'b0;
      en_op     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_n;
      armed     <= 1'b1;
      cnt       <= cnt_n;
      load_d    <= load_d_n;
      en_a      <= en_a_n;
      en_b      <= en_b_n;
      en_op     <= en_op_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: two instances (settle 2 and 4) share stimulus and are
// compared every cycle against a transaction-level model, with directed literal checks on top.
module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [7:0] alu_result = 8'h00;
  logic       out_ready = 1'b0;

  logic       in_ready [2];
  logic [7:0] load_d [2];
  logic       en_a [2];
  logic       en_b [2];
  logic       en_op [2];
  logic       out_valid [2];
  logic [7:0] out_data [2];

  int checks = 0;
  int errors = 0;
  int pulses0 = 0;
  int valid4 = 0;
  int base;

  always #5 clk = ~clk;

  alu_operand_sequencer #(.WIDTH(8), .EXEC_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[0]), .load_d(load_d[0]), .en_a(en_a[0]), .en_b(en_b[0]), .en_op(en_op[0]),
    .alu_result(alu_result), .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready)
  );

  alu_operand_sequencer #(.WIDTH(8), .EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[1]), .load_d(load_d[1]), .en_a(en_a[1]), .en_b(en_b[1]), .en_op(en_op[1]),
    .alu_result(alu_result), .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready)
  );

  // Model: bytes collected so far (0..2, 3 = busy), remaining settle edges, pending result
  int         phase [2];
  int         left [2];
  bit         armed [2];
  bit         mv [2];
  logic [7:0] mload [2];
  logic [7:0] mdata [2];
  logic [2:0] men [2];

  function automatic int settle(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        phase[i] = 0; left[i] = 0; armed[i] = 0; mv[i] = 0;
        mload[i] = 8'h00; mdata[i] = 8'h00; men[i] = 3'b000;
      end else begin
        men[i] = 3'b000;
        if (clear) begin
          phase[i] = 0;
          mv[i] = 0;
        end else if (phase[i] < 3) begin
          if (armed[i] && in_valid) begin
            mload[i] = in_data;
            men[i] = 3'b100 >> phase[i];
            if (phase[i] == 2) begin
              phase[i] = 3;
              left[i] = settle(i);
            end else begin
              phase[i] = phase[i] + 1;
            end
          end
        end else if (mv[i]) begin
          if (out_ready) begin
            mv[i] = 0;
            phase[i] = 0;
          end
        end else begin
          left[i] = left[i] - 1;
          if (left[i] == 0) begin
            mv[i] = 1;
            mdata[i] = alu_result;
          end
        end
        armed[i] = 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("model_dut%0d", i),
        {11'd0, in_ready[i], en_a[i], en_b[i], en_op[i], out_valid[i], load_d[i], out_data[i]},
        {11'd0, (armed[i] && phase[i] < 3) ? 1'b1 : 1'b0, men[i], mv[i], mload[i], mdata[i]});
    end
    if (en_a[0] || en_b[0] || en_op[0]) pulses0++;
    if (out_valid[1]) valid4++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic clr);
    in_valid = v;
    in_data = d;
    clear = clr;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h99;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", in_ready[0], 0);
    checkOutput("reset_en", {en_a[0], en_b[0], en_op[0]}, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1 checkOutput("release_pre_edge_ready", in_ready[0], 0);
    tick();
    checkOutput("release_ready", in_ready[0], 1);
    checkOutput("release_out_valid", out_valid[0], 0);
    checkOutput("release_out_data", out_data[0], 0);

    // full operation with backpressure
    alu_result = 8'h41;
    out_ready = 1'b0;
    applyStimulus(1'b1, 8'h3C, 1'b0);
    checkOutput("en_a_pulse", {en_a[0], en_b[0], en_op[0]}, 3'b100);
    checkOutput("load_a", load_d[0], 8'h3C);
    applyStimulus(1'b1, 8'h05, 1'b0);
    checkOutput("en_b_pulse", {en_a[0], en_b[0], en_op[0]}, 3'b010);
    checkOutput("load_b", load_d[0], 8'h05);
    applyStimulus(1'b1, 8'h01, 1'b0);
    checkOutput("en_op_pulse", {en_a[0], en_b[0], en_op[0]}, 3'b001);
    checkOutput("load_op", load_d[0], 8'h01);
    checkOutput("exec_not_ready", in_ready[0], 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("valid_not_early", out_valid[0], 0);
    checkOutput("load_d_holds", load_d[0], 8'h01);
    tick();
    checkOutput("valid_latency", out_valid[0], 1);
    checkOutput("result_data", out_data[0], 8'h41);
    for (int i = 0; i < 10; i++) begin
      alu_result = 8'(i * 7);
      tick();
      checkOutput("hold_data", out_data[0], 8'h41);
      checkOutput("hold_not_ready", in_ready[0], 0);
    end
    out_ready = 1'b1;
    tick();
    checkOutput("drain_valid", out_valid[0], 0);
    checkOutput("drain_ready", in_ready[0], 1);

    // input gaps, plus a byte offered during EXEC
    alu_result = 8'h5A;
    base = pulses0;
    applyStimulus(1'b1, 8'hAA, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'hBB, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'hCC, 1'b0);
    in_data = 8'hDD;
    tick();
    tick();
    checkOutput("gap_result_valid", out_valid[0], 1);
    checkOutput("gap_result_data", out_data[0], 8'h5A);
    tick();
    checkOutput("gap_pulse_count", pulses0 - base, 3);
    tick();
    checkOutput("back_to_back_en_a", en_a[0], 1);
    checkOutput("back_to_back_load", load_d[0], 8'hDD);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);

    // clear coinciding with the opcode byte
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b1);
    checkOutput("clear_no_en", {en_a[0], en_b[0], en_op[0]}, 0);
    checkOutput("clear_load_holds", load_d[0], 8'h22);
    applyStimulus(1'b1, 8'h10, 1'b0);
    checkOutput("after_clear_en_a", {en_a[0], en_b[0], en_op[0]}, 3'b100);
    checkOutput("after_clear_load", load_d[0], 8'h10);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);

    // asynchronous reset while the 4-cycle instance is in EXEC
    alu_result = 8'h99;
    base = valid4;
    applyStimulus(1'b1, 8'h01, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0);
    applyStimulus(1'b1, 8'h03, 1'b0);
    checkOutput("dut4_en_op", en_op[1], 1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", out_valid[1], 0);
    checkOutput("async_en", {en_a[1], en_b[1], en_op[1]}, 0);
    checkOutput("async_in_ready", in_ready[1], 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checkOutput("restart_ready", in_ready[1], 1);
    applyStimulus(1'b1, 8'h42, 1'b0);
    checkOutput("restart_en_a", {en_a[1], en_b[1], en_op[1]}, 3'b100);
    checkOutput("restart_load", load_d[1], 8'h42);
    checkOutput("lost_result", valid4 - base, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
